// File: rtl/alu_shift16_ctrl.sv
// alu_shift16_ctrl
// Sequences a 16-bit logical shift (hi:lo) through the core's 8-bit ALU in
// shift-by-immediate mode. Each bit of shift takes two ALU passes, one per
// byte. The cross-byte carry is stitched here, so the ALU carry flag is never
// needed. While shifting, the block owns the ALU operand path. When idle it
// releases the path to normal decode.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start             request, sampled only in IDLE/DONE
//   dir               0 = logical left, 1 = logical right (zero fill)
//   amount[3:0]       shift count 0..15
//   hi_in, lo_in      operand bytes
//   alu_result        combinational ALU output for this cycle's operands
//   alu_own           core mux selects this block's ALU operands
//   shift_imm_enable  immediate selected as ALU operand 2
//   shift_imm         immediate shift count (1 while owning)
//   alu_shr           ALU shift direction (1 = right)
//   alu_a             ALU operand 1
//   busy              high in the shift states
//   done              one-cycle pulse, result valid
//   res_hi, res_lo    result bytes
module alu_shift16_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dir,
  input  logic [3:0] amount,
  input  logic [7:0] hi_in,
  input  logic [7:0] lo_in,
  input  logic [7:0] alu_result,
  output logic       alu_own,
  output logic       shift_imm_enable,
  output logic [7:0] shift_imm,
  output logic       alu_shr,
  output logic [7:0] alu_a,
  output logic       busy,
  output logic       done,
  output logic [7:0] res_hi,
  output logic [7:0] res_lo
);

  typedef enum logic [1:0] {IDLE, SH_FIRST, SH_SECOND, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] work_hi, work_lo;
  logic [3:0] cnt;
  logic       dir_r;
  logic       carry;
  logic       accept;

  assign accept = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    alu_own          = 1'b0;
    shift_imm_enable = 1'b0;
    shift_imm        = 8'd0;
    alu_shr          = 1'b0;
    alu_a            = 8'd0;
    busy             = 1'b0;
    done             = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_nxt = (amount == 4'd0) ? DONE : SH_FIRST;
        else       state_nxt = IDLE;
      end
      SH_FIRST, SH_SECOND: begin
        alu_own          = 1'b1;
        shift_imm_enable = 1'b1;
        shift_imm        = 8'd1;
        alu_shr          = dir_r;
        busy             = 1'b1;
        // Left processes lo first so its msb can carry into hi; right
        // processes hi first so its lsb can carry into lo.
        if (state == SH_FIRST) begin
          alu_a     = dir_r ? work_hi : work_lo;
          state_nxt = SH_SECOND;
        end else begin
          alu_a     = dir_r ? work_lo : work_hi;
          state_nxt = (cnt == 4'd1) ? DONE : SH_FIRST;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_hi <= 8'd0;
      work_lo <= 8'd0;
      cnt     <= 4'd0;
      dir_r   <= 1'b0;
      carry   <= 1'b0;
    end else if (accept) begin
      work_hi <= hi_in;
      work_lo <= lo_in;
      cnt     <= amount;
      dir_r   <= dir;
    end else if (state == SH_FIRST) begin
      // Capture the bit leaving the first byte from its pre-shift value.
      if (dir_r) begin
        work_hi <= alu_result;
        carry   <= work_hi[0];
      end else begin
        work_lo <= alu_result;
        carry   <= work_lo[7];
      end
    end else if (state == SH_SECOND) begin
      if (dir_r) work_lo <= alu_result | {carry, 7'b0};
      else       work_hi <= alu_result | {7'b0, carry};
      cnt <= cnt - 4'd1;
    end
  end

  assign res_hi = work_hi;
  assign res_lo = work_lo;

endmodule

// File: tb/tb_alu_shift16_ctrl.sv
// Scoreboard bench for alu_shift16_ctrl. The driver pushes each accepted
// operation, with its arithmetic 16-bit result and expected timing, into a
// queue. A negedge monitor derives per-cycle expectations from the queue
// front and checks them.
module tb_alu_shift16_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, dir;
  logic [3:0] amount;
  logic [7:0] hi_in, lo_in, alu_result;
  logic       alu_own, shift_imm_enable, alu_shr, busy, done;
  logic [7:0] shift_imm, alu_a, res_hi, res_lo;

  always #5 clk = ~clk;

  // Environment ALU: pure logical shift with zero fill.
  assign alu_result = shift_imm_enable ? (alu_shr ? (alu_a >> shift_imm) : (alu_a << shift_imm)) : 8'h00;

  alu_shift16_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .amount(amount),
    .hi_in(hi_in), .lo_in(lo_in), .alu_result(alu_result),
    .alu_own(alu_own), .shift_imm_enable(shift_imm_enable), .shift_imm(shift_imm),
    .alu_shr(alu_shr), .alu_a(alu_a), .busy(busy), .done(done),
    .res_hi(res_hi), .res_lo(res_lo)
  );

  typedef struct {
    logic [15:0] orig;
    logic        d;
    int          n;
    int          start_cyc;
    int          done_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_alu_own"}, int'(alu_own), 0);
    chk({tag, "_imm_en"}, int'(shift_imm_enable), 0);
    chk({tag, "_imm"}, int'(shift_imm), 0);
    chk({tag, "_shr"}, int'(alu_shr), 0);
    chk({tag, "_alu_a"}, int'(alu_a), 0);
    chk({tag, "_res_hi"}, int'(res_hi), 0);
    chk({tag, "_res_lo"}, int'(res_lo), 0);
  endtask

  // Monitor: expectations come from the front operation only.
  always @(negedge clk) begin
    exp_t        e;
    bit          eb, ed;
    int          j, ph;
    logic [15:0] v, r;
    logic [7:0]  ea;
    if (mon_en) begin
      eb = 1'b0; ed = 1'b0; ea = 8'h00;
      if (q.size() > 0) begin
        e  = q[0];
        eb = (cyc >= e.start_cyc) && (cyc < e.done_cyc);
        ed = (cyc == e.done_cyc);
        if (eb) begin
          j  = (cyc - e.start_cyc) / 2;
          ph = (cyc - e.start_cyc) % 2;
          v  = e.d ? (e.orig >> j) : (e.orig << j);
          if (ph == 0) ea = e.d ? v[15:8] : v[7:0];
          else         ea = e.d ? v[7:0]  : v[15:8];
        end
      end
      chk("busy", int'(busy), int'(eb));
      chk("alu_own", int'(alu_own), int'(eb));
      chk("imm_en", int'(shift_imm_enable), int'(eb));
      chk("imm", int'(shift_imm), eb ? 1 : 0);
      chk("shr", int'(alu_shr), eb ? int'(e.d) : 0);
      chk("alu_a", int'(alu_a), int'(ea));
      chk("done", int'(done), int'(ed));
      if (ed) begin
        r = e.d ? (e.orig >> e.n) : (e.orig << e.n);
        chk("res_hi", int'(res_hi), int'(r[15:8]));
        chk("res_lo", int'(res_lo), int'(r[7:0]));
        void'(q.pop_front());
      end
    end
  end

  // Called at a negedge. Returns at the negedge of the DONE cycle with start low.
  // With noise, random start pulses carrying other operands hit the busy window.
  task automatic run_op(input logic d, input int n, input logic [7:0] h, input logic [7:0] l,
                        input bit noise);
    exp_t e;
    dir = d; amount = 4'(n); hi_in = h; lo_in = l; start = 1'b1;
    e.orig = {h, l}; e.d = d; e.n = n;
    e.start_cyc = cyc + 1; e.done_cyc = cyc + 1 + 2 * n;
    q.push_back(e);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 2 * n; i++) begin
      if (noise && $urandom_range(0, 3) == 0) begin
        start = 1'b1; dir = 1'($urandom); amount = 4'($urandom);
        hi_in = 8'($urandom); lo_in = 8'($urandom);
      end
      @(negedge clk); start = 1'b0;
    end
  endtask

  task automatic idle(input int m);
    repeat (m) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with start asserted and random operands.
    rst_n = 1'b0; start = 1'b1; dir = 1'($urandom); amount = 4'($urandom_range(1, 15));
    hi_in = 8'($urandom); lo_in = 8'($urandom);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1; start = 1'b0;
    mon_en = 1'b1;
    idle(3);

    // Directed cases.
    run_op(1'b0, 1, 8'h12, 8'h81, 1'b0);
    idle(2);
    run_op(1'b1, 4, 8'h81, 8'h00, 1'b0);
    idle(1);
    run_op(1'b0, 0, 8'hA5, 8'h5A, 1'b0);
    idle(2);
    run_op(1'b0, 15, 8'h00, 8'h01, 1'b1);
    run_op(1'b1, 1, 8'h80, 8'h00, 1'b0);   // accepted in the DONE cycle
    run_op(1'b0, 0, 8'h3C, 8'hC3, 1'b0);   // back-to-back, amount 0
    run_op(1'b1, 0, 8'h11, 8'h22, 1'b0);
    idle(2);

    // Reset mid-operation: rst_n low at the third edge after acceptance.
    dir = 1'b1; amount = 4'd8; hi_in = 8'hFF; lo_in = 8'hFF; start = 1'b1;
    begin
      exp_t e;
      e.orig = 16'hFFFF; e.d = 1'b1; e.n = 8;
      e.start_cyc = cyc + 1; e.done_cyc = cyc + 17;
      q.push_back(e);
    end
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); q.delete();
    @(negedge clk);
    chk_zero("midreset");
    @(negedge clk); rst_n = 1'b1;
    idle(20);                               // no stale done may appear
    run_op(1'b0, 3, 8'h0F, 8'hF0, 1'b0);

    // Randomized operations with ignored starts and random gaps.
    for (int k = 0; k < 24; k++) begin
      run_op(1'($urandom), $urandom_range(0, 15), 8'($urandom), 8'($urandom), 1'b1);
      idle($urandom_range(0, 2));
    end
    idle(3);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_shift16_ctrl.md
# alu_shift16_ctrl

Multi-cycle sequencer that performs a 16-bit logical shift (hi:lo byte pair) using the core's 8-bit ALU in shift-by-immediate mode. The shift is done one bit at a time, and each bit takes two ALU passes (one per byte). The block stitches the cross-byte carry itself. While busy it takes ownership of the ALU input select and operand path; when idle it releases the path to normal instruction decode.

## Interface

Parameters: none (byte width fixed at 8, shift amount fixed at 4 bits).

- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only when not busy
- dir  in  1  0 = logical left, 1 = logical right (zero fill)
- amount  in  4  shift count, 0..15
- hi_in  in  8  upper byte of operand
- lo_in  in  8  lower byte of operand
- alu_result  in  8  combinational ALU output for the operands driven this cycle
- alu_own  out  1  1 = this block drives the ALU inputs (core mux selects this block)
- shift_imm_enable  out  1  selects immediate as ALU operand 2
- shift_imm  out  8  immediate shift count, constant 8'd1 while owning, else 0
- alu_shr  out  1  ALU shift direction (1 = right)
- alu_a  out  8  ALU operand 1
- busy  out  1  high in shift states
- done  out  1  one-cycle pulse, result valid
- res_hi, res_lo  out  8 each  result bytes

## Operation

- Internal state: work_hi, work_lo, cnt[3:0], dir_r, carry (1 bit), FSM {IDLE, SH_FIRST, SH_SECOND, DONE}.
- IDLE or DONE with start=1: latch hi_in, lo_in, dir, amount.
  - amount==0: go to DONE.
  - Otherwise go to SH_FIRST.
- IDLE or DONE with start=0: DONE→IDLE, IDLE holds.
- SH_FIRST / SH_SECOND byte order:
  - Left: first = lo, second = hi.
  - Right: first = hi, second = lo.
- SH_FIRST:
  - Drive alu_a = first byte.
  - Write first byte ← alu_result.
  - carry ← bit shifted out of first byte (left: lo[7]; right: hi[0]), taken from the pre-shift value.
  - Next state SH_SECOND.
- SH_SECOND:
  - Drive alu_a = second byte.
  - Left: hi ← alu_result | {7'b0, carry}.
  - Right: lo ← alu_result | {carry, 7'b0}.
  - cnt ← cnt−1. If cnt==1 (before decrement), go to DONE; else go to SH_FIRST.
- Owning outputs:
  - In SH_FIRST/SH_SECOND: alu_own=1, shift_imm_enable=1, shift_imm=1, alu_shr=dir_r.
  - In IDLE/DONE: alu_own=0, shift_imm_enable=0, shift_imm=0, alu_shr=0, alu_a=0.
- res_hi/res_lo = work_hi/work_lo continuously; stable from done until the next accepted start.
- start while busy (SH_FIRST/SH_SECOND): ignored, no effect on latched operands.
- The ALU is assumed to be a pure logical shift with zero fill. The block never depends on ALU carry flags.

## Timing

- Reset (rst_n=0 at a rising edge): FSM=IDLE, work_hi=work_lo=0, cnt=0, carry=0, dir_r=0. All outputs are 0, including done, busy, alu_own, res_hi and res_lo.
- Reset dominates start and any in-flight shift. Reset mid-operation aborts it: no done pulse, results cleared.
- Start accepted at edge E0:
  - amount n ≥ 1: busy high from E0 to E(2n). DONE is entered at E(2n). done is high for exactly the cycle E(2n)..E(2n+1). Latency is 2n cycles.
  - amount 0: DONE entered at E0, done high for cycle E0..E1, busy never asserted, results = inputs.
- Back-to-back: start asserted during the DONE cycle is accepted at that edge. done still deasserts next cycle unless the new amount is 0.
- alu_result is sampled on the same edge as the operands are driven (single-cycle combinational ALU). There is no wait state.
- Maximum latency is 30 cycles (n=15).

## Test plan

- Reset: hold rst_n=0 for 2 cycles with start=1 and random inputs → all outputs 0, FSM IDLE. Release → no spurious done.
- Left n=1, hi=0x12, lo=0x81 → SH_FIRST drives alu_a=0x81, SH_SECOND drives alu_a=0x12. done at E0+2, res=0x25/0x02, busy high for exactly 2 cycles.
- Right n=4, hi=0x81, lo=0x00 → done at E0+8, res=0x08/0x10. alu_shr=1 and shift_imm_enable=1 for all 8 busy cycles.
- n=0, hi=0xA5, lo=0x5A → done the cycle after start, res=0xA5/0x5A, alu_own never high.
- Left n=15, hi=0x00, lo=0x01 → done at E0+30, res=0x80/0x00. A start pulse with different operands at E0+5 is ignored. A start in the DONE cycle with n=1 right, hi=0x80, lo=0x00 → second done 2 cycles later, res=0x40/0x00.
- Reset mid-op: right n=8 operand 0xFFFF, rst_n=0 at E0+3 → outputs 0 next cycle, no done pulse. A fresh start after release behaves normally.
